vga_text_vram_sequencer: RTL and testbench

- Owns the single-port 600-word text VRAM (80x30 characters, 4 glyph bytes per word) behind the VGA text-mode display.
- Arbitrates three requesters: the VGA character fetch, the Avalon CPU port, and an internal bulk engine.
- The bulk engine clears, fills or scrolls the screen on a single command, so software no longer rewrites all 600 words itself.

---
 rtl/vga_text_vram_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_vga_text_vram_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_vram_sequencer.sv
// Text-mode VRAM sequencer: arbitrates the single-port 600-word text VRAM
// between the VGA character fetch, the CPU port and an internal bulk engine
// that clears, fills or scrolls the whole screen on one command.
//
// Handshakes:
//   - Command port: a command is taken on a cycle where CMD_VALID & CMD_READY.
//     CMD_READY is high only while the engine is idle. A CMD_VALID seen while
//     busy is dropped, not queued.
//   - VGA / CPU ports: the requester raises REQ with stable fields and holds
//     them until it sees ACK for one cycle. ACK (and RDATA for reads) arrives
//     exactly one cycle after the grant.
module vga_text_vram_sequencer #(
    parameter int WORDS_PER_ROW = 20,
    parameter int NUM_ROWS      = 30,
    parameter int ADDR_W        = 10
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [1:0]        CMD_OP,
    input  logic [7:0]        CMD_FILL,
    output logic              BUSY,
    output logic              DONE,
    input  logic              VGA_REQ,
    input  logic [ADDR_W-1:0] VGA_ADDR,
    output logic              VGA_ACK,
    output logic [31:0]       VGA_RDATA,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [3:0]        CPU_BE,
    input  logic [31:0]       CPU_WDATA,
    output logic              CPU_ACK,
    output logic [31:0]       CPU_RDATA,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              RAM_WE,
    output logic [3:0]        RAM_BE,
    output logic [31:0]       RAM_WDATA,
    input  logic [31:0]       RAM_RDATA
);

    localparam int TOTAL_WORDS = WORDS_PER_ROW * NUM_ROWS;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(TOTAL_WORDS - 1);
    localparam logic [ADDR_W-1:0] SCROLL_END = ADDR_W'(TOTAL_WORDS - WORDS_PER_ROW);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(WORDS_PER_ROW);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLR      = 3'd1,
        ST_SCR_RD   = 3'd2,
        ST_SCR_WR   = 3'd3,
        ST_SCR_FILL = 3'd4,
        ST_FIN      = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [31:0]       fill_q, fill_d;
    logic [31:0]       hold_q, hold_d;
    logic              rd_pend_q, rd_pend_d;
    logic              vga_pend_q, vga_pend_d;
    logic              cpu_pend_q, cpu_pend_d;
    logic              vga_ack_q, vga_ack_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [31:0]       vga_rdata_q, vga_rdata_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;

    logic              gnt_vga, gnt_cpu, gnt_eng;
    logic              eng_req, eng_we;
    logic [ADDR_W-1:0] eng_addr, ptr_inc;
    logic [31:0]       eng_wdata, hold_data;

    // Fixed-priority arbiter (VGA > CPU > engine), at most one grant per cycle.
    always_comb begin
        eng_req = (state_q == ST_CLR) || (state_q == ST_SCR_RD) ||
                  (state_q == ST_SCR_WR) || (state_q == ST_SCR_FILL);
        gnt_vga = VGA_REQ && !vga_pend_q;
        gnt_cpu = CPU_REQ && !cpu_pend_q && !gnt_vga;
        gnt_eng = eng_req && !gnt_vga && !gnt_cpu;
    end

    // Engine access fields; the scroll write uses the read data live in the
    // cycle it returns, otherwise the copy parked in the hold register.
    always_comb begin
        hold_data = rd_pend_q ? RAM_RDATA : hold_q;
        eng_we    = (state_q != ST_SCR_RD);
        eng_addr  = (state_q == ST_SCR_RD) ? (ptr_q + ROW_STEP) : ptr_q;
        eng_wdata = (state_q == ST_SCR_WR) ? hold_data : fill_q;
        ptr_inc   = ptr_q + 1'b1;
    end

    // RAM port mux: the granted requester drives the RAM in its grant cycle.
    always_comb begin
        RAM_ADDR  = '0;
        RAM_WE    = 1'b0;
        RAM_BE    = 4'b0000;
        RAM_WDATA = '0;
        if (gnt_vga) begin
            RAM_ADDR = VGA_ADDR;
        end else if (gnt_cpu) begin
            RAM_ADDR  = CPU_ADDR;
            RAM_WE    = CPU_WE;
            RAM_BE    = CPU_WE ? CPU_BE : 4'b0000;
            RAM_WDATA = CPU_WDATA;
        end else if (gnt_eng) begin
            RAM_ADDR  = eng_addr;
            RAM_WE    = eng_we;
            RAM_BE    = eng_we ? 4'b1111 : 4'b0000;
            RAM_WDATA = eng_wdata;
        end
    end

    // Engine next-state and pointer; a step only advances when it was granted.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        fill_d  = fill_q;
        case (state_q)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    ptr_d  = '0;
                    fill_d = {4{CMD_FILL}};
                    case (CMD_OP)
                        2'b00: begin
                            state_d = ST_CLR;
                            fill_d  = '0;
                        end
                        2'b01:   state_d = ST_SCR_RD;
                        2'b10:   state_d = ST_CLR;
                        default: state_d = ST_FIN;
                    endcase
                end
            end
            ST_CLR, ST_SCR_FILL: begin
                if (gnt_eng) begin
                    if (ptr_q == LAST_ADDR) begin
                        state_d = ST_FIN;
                    end else begin
                        ptr_d = ptr_inc;
                    end
                end
            end
            ST_SCR_RD: begin
                if (gnt_eng) begin
                    state_d = ST_SCR_WR;
                end
            end
            ST_SCR_WR: begin
                if (gnt_eng) begin
                    ptr_d   = ptr_inc;
                    state_d = (ptr_inc < SCROLL_END) ? ST_SCR_RD : ST_SCR_FILL;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Acknowledge, pending and read-data bookkeeping for all requesters.
    always_comb begin
        hold_d      = hold_data;
        rd_pend_d   = gnt_eng && (state_q == ST_SCR_RD);
        vga_ack_d   = gnt_vga;
        cpu_ack_d   = gnt_cpu;
        // Pending covers the grant's ACK cycle, limiting each port to one
        // access every two cycles.
        vga_pend_d  = gnt_vga || (vga_pend_q && !vga_ack_q);
        cpu_pend_d  = gnt_cpu || (cpu_pend_q && !cpu_ack_q);
        vga_rdata_d = vga_ack_q ? RAM_RDATA : vga_rdata_q;
        cpu_rdata_d = cpu_ack_q ? RAM_RDATA : cpu_rdata_q;
    end

    // Outputs derived from state and the registered acknowledge path.
    always_comb begin
        BUSY      = (state_q != ST_IDLE);
        CMD_READY = (state_q == ST_IDLE);
        DONE      = (state_q == ST_FIN);
        VGA_ACK   = vga_ack_q;
        CPU_ACK   = cpu_ack_q;
        VGA_RDATA = vga_rdata_d;
        CPU_RDATA = cpu_rdata_d;
    end

    // State register; reset aborts any engine operation immediately.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            fill_q      <= '0;
            hold_q      <= '0;
            rd_pend_q   <= 1'b0;
            vga_pend_q  <= 1'b0;
            cpu_pend_q  <= 1'b0;
            vga_ack_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            vga_rdata_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            fill_q      <= fill_d;
            hold_q      <= hold_d;
            rd_pend_q   <= rd_pend_d;
            vga_pend_q  <= vga_pend_d;
            cpu_pend_q  <= cpu_pend_d;
            vga_ack_q   <= vga_ack_d;
            cpu_ack_q   <= cpu_ack_d;
            vga_rdata_q <= vga_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

endmodule

// File: tb/tb_vga_text_vram_sequencer.sv
// Bench for the text VRAM sequencer: a synchronous VRAM model, CPU/VGA/command
// drivers, and a word-level model of the screen contents.
module tb_vga_text_vram_sequencer;

    localparam int AW = 10;
    localparam int NW = 600;
    localparam int RW = 20;

    logic          CLK       = 1'b0;
    logic          RESET_N   = 1'b0;
    logic          CMD_VALID = 1'b0;
    logic          CMD_READY;
    logic [1:0]    CMD_OP    = 2'b00;
    logic [7:0]    CMD_FILL  = 8'h00;
    logic          BUSY;
    logic          DONE;
    logic          VGA_REQ   = 1'b0;
    logic [AW-1:0] VGA_ADDR  = '0;
    logic          VGA_ACK;
    logic [31:0]   VGA_RDATA;
    logic          CPU_REQ   = 1'b0;
    logic          CPU_WE    = 1'b0;
    logic [AW-1:0] CPU_ADDR  = '0;
    logic [3:0]    CPU_BE    = 4'b0000;
    logic [31:0]   CPU_WDATA = '0;
    logic          CPU_ACK;
    logic [31:0]   CPU_RDATA;
    logic [AW-1:0] RAM_ADDR;
    logic          RAM_WE;
    logic [3:0]    RAM_BE;
    logic [31:0]   RAM_WDATA;
    logic [31:0]   RAM_RDATA = '0;

    logic [31:0] mem     [0:1023];
    logic [31:0] pre_img [0:1023];
    logic [31:0] model   [0:NW-1];
    logic [31:0] exp_q[$];
    logic        pre_go = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;

    vga_text_vram_sequencer #(.WORDS_PER_ROW(RW), .NUM_ROWS(30), .ADDR_W(AW)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP), .CMD_FILL(CMD_FILL),
        .BUSY(BUSY), .DONE(DONE),
        .VGA_REQ(VGA_REQ), .VGA_ADDR(VGA_ADDR), .VGA_ACK(VGA_ACK), .VGA_RDATA(VGA_RDATA),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_BE(CPU_BE),
        .CPU_WDATA(CPU_WDATA), .CPU_ACK(CPU_ACK), .CPU_RDATA(CPU_RDATA),
        .RAM_ADDR(RAM_ADDR), .RAM_WE(RAM_WE), .RAM_BE(RAM_BE), .RAM_WDATA(RAM_WDATA),
        .RAM_RDATA(RAM_RDATA)
    );

    // Clock
    always #5 CLK = ~CLK;

    // Synchronous single-port VRAM with byte enables, plus event counters
    always @(posedge CLK) begin
        if (pre_go) begin
            for (int i = 0; i < 1024; i++) mem[i] <= pre_img[i];
        end else if (RAM_WE) begin
            for (int b = 0; b < 4; b++)
                if (RAM_BE[b]) mem[RAM_ADDR][8*b +: 8] <= RAM_WDATA[8*b +: 8];
        end
        RAM_RDATA <= mem[RAM_ADDR];
        if (RAM_WE) wr_cnt <= wr_cnt + 1;
        if (DONE) done_cnt <= done_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // kind 0: zeros, 1: {random, n}, 2: 0xA5000000 | n
    task automatic preload(input int kind);
        for (int i = 0; i < 1024; i++) begin
            case (kind)
                0:       pre_img[i] = 32'h0;
                1:       pre_img[i] = {16'($urandom), 16'(i)};
                default: pre_img[i] = 32'hA500_0000 | 32'(i);
            endcase
        end
        for (int i = 0; i < NW; i++) model[i] = pre_img[i];
        pre_go = 1'b1;
        step();
        pre_go = 1'b0;
    endtask

    task automatic cpu_access(input logic we, input int addr, input logic [3:0] be,
                              input logic [31:0] wdata, output logic [31:0] rdata,
                              output int lat);
        CPU_REQ = 1'b1; CPU_WE = we; CPU_ADDR = AW'(addr); CPU_BE = be; CPU_WDATA = wdata;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!CPU_ACK && lat < 20);
        rdata = CPU_RDATA;
        CPU_REQ = 1'b0; CPU_WE = 1'b0;
        step();
    endtask

    task automatic cpu_write(input int addr, input logic [3:0] be, input logic [31:0] wdata);
        logic [31:0] rd;
        int lat;
        for (int b = 0; b < 4; b++)
            if (be[b]) model[addr][8*b +: 8] = wdata[8*b +: 8];
        cpu_access(1'b1, addr, be, wdata, rd, lat);
        check("cpu_wr_lat", 32'(lat), 32'd1);
    endtask

    task automatic cpu_read(input int addr);
        logic [31:0] rd;
        int lat;
        exp_q.push_back(model[addr]);
        cpu_access(1'b0, addr, 4'b0000, 32'h0, rd, lat);
        check("cpu_rd_lat", 32'(lat), 32'd1);
        check("cpu_rd_data", rd, exp_q.pop_front());
    endtask

    task automatic start_cmd(input logic [1:0] op, input logic [7:0] fill);
        int n = 0;
        while (!CMD_READY && n < 20) begin
            step();
            n++;
        end
        check("cmd_ready", CMD_READY, 1'b1);
        CMD_OP = op; CMD_FILL = fill; CMD_VALID = 1'b1;
        step();
        CMD_VALID = 1'b0;
    endtask

    // Counts cycles from accept to DONE; optional VGA traffic and busy poke
    task automatic wait_done(input bit traffic, input bit poke, output int cyc);
        int cnt = 1;
        bit vpend = 1'b0;
        logic [31:0] vexp = '0;
        while (!DONE && cnt < 5000) begin
            if (vpend) begin
                check("vga_ack_lat", VGA_ACK, 1'b1);
                check("vga_rdata", VGA_RDATA, vexp);
                VGA_REQ = 1'b0;
                vpend = 1'b0;
            end
            if (poke && cnt == 10) begin
                CMD_VALID = 1'b1; CMD_OP = 2'b01;
                check("ready_while_busy", CMD_READY, 1'b0);
            end
            if (poke && cnt == 14) CMD_VALID = 1'b0;
            if (traffic && (cnt % 64) == 0) begin
                VGA_ADDR = AW'($urandom_range(0, NW - 1));
                VGA_REQ = 1'b1;
                vexp = mem[VGA_ADDR];
                vpend = 1'b1;
            end
            step();
            cnt++;
        end
        if (vpend) begin
            check("vga_ack_lat", VGA_ACK, 1'b1);
            check("vga_rdata", VGA_RDATA, vexp);
            VGA_REQ = 1'b0;
        end
        if (!DONE) check("done_timeout", 32'd0, 32'd1);
        cyc = cnt;
    endtask

    task automatic compare_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < NW; i++)
            if (mem[i] !== model[i]) bad++;
        check(tag, 32'(bad), 32'd0);
    endtask

    task automatic finish_op(input int d0);
        step();
        check("done_one_cycle", DONE, 1'b0);
        check("busy_after_done", BUSY, 1'b0);
        repeat (20) step();
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int cyc, d0, w0;
        logic [31:0] pre [0:NW-1];
        logic [7:0] f;

        // Reset state
        preload(0);
        repeat (3) step();
        check("rst_cmd_ready", CMD_READY, 1'b1);
        check("rst_busy", BUSY, 1'b0);
        check("rst_done", DONE, 1'b0);
        check("rst_ram_we", RAM_WE, 1'b0);
        check("rst_ram_addr", 32'(RAM_ADDR), 32'd0);
        check("rst_vga_ack", VGA_ACK, 1'b0);
        check("rst_cpu_ack", CPU_ACK, 1'b0);
        check("rst_vga_rdata", VGA_RDATA, 32'h0);
        check("rst_cpu_rdata", CPU_RDATA, 32'h0);
        RESET_N = 1'b1;
        step();

        // Basic CPU write and readback
        cpu_write(5, 4'b1111, 32'h41424344);
        cpu_read(5);

        // Simultaneous VGA and CPU requests: VGA wins, CPU follows
        VGA_REQ = 1'b1; VGA_ADDR = AW'(5);
        CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = AW'(5);
        step();
        check("prio_vga_ack", VGA_ACK, 1'b1);
        check("prio_cpu_wait", CPU_ACK, 1'b0);
        check("prio_vga_data", VGA_RDATA, 32'h41424344);
        VGA_REQ = 1'b0;
        step();
        check("prio_cpu_ack", CPU_ACK, 1'b1);
        check("prio_vga_done", VGA_ACK, 1'b0);
        check("prio_cpu_data", CPU_RDATA, 32'h41424344);
        CPU_REQ = 1'b0;
        step();

        // Byte-enable merge
        cpu_write(9, 4'b1111, 32'h11223344);
        cpu_write(9, 4'b0010, 32'h0000AA00);
        check("be_model", model[9], 32'h1122AA44);
        cpu_read(9);

        // Random CPU traffic against the word model
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 1)
                cpu_write($urandom_range(0, NW - 1), 4'($urandom_range(0, 15)), $urandom);
            else
                cpu_read($urandom_range(0, NW - 1));
        end

        // Fill with 0x20, busy commands ignored
        d0 = done_cnt;
        start_cmd(2'b10, 8'h20);
        wait_done(1'b0, 1'b1, cyc);
        check("fill_cycles", 32'(cyc), 32'd601);
        for (int i = 0; i < NW; i++) model[i] = 32'h20202020;
        finish_op(d0);
        compare_mem("fill_words");

        // Scroll with VGA traffic every 64 cycles
        preload(1);
        for (int i = 0; i < NW; i++) pre[i] = model[i];
        for (int i = 0; i < NW; i++) model[i] = (i < NW - RW) ? pre[i + RW] : 32'h0;
        d0 = done_cnt;
        start_cmd(2'b01, 8'h00);
        wait_done(1'b1, 1'b0, cyc);
        finish_op(d0);
        compare_mem("scroll_vga_words");

        // Uncontended scroll with a random blank glyph
        f = 8'($urandom_range(1, 255));
        for (int i = 0; i < NW; i++) pre[i] = model[i];
        for (int i = 0; i < NW; i++) model[i] = (i < NW - RW) ? pre[i + RW] : {4{f}};
        d0 = done_cnt;
        start_cmd(2'b01, f);
        wait_done(1'b0, 1'b0, cyc);
        check("scroll_cycles", 32'(cyc), 32'd1181);
        finish_op(d0);
        compare_mem("scroll_words");
        cpu_read(NW - 1);
        cpu_read(0);

        // Clear ignores the fill byte
        d0 = done_cnt;
        start_cmd(2'b00, 8'hFF);
        wait_done(1'b0, 1'b0, cyc);
        check("clear_cycles", 32'(cyc), 32'd601);
        for (int i = 0; i < NW; i++) model[i] = 32'h0;
        finish_op(d0);
        compare_mem("clear_words");

        // Reserved op: no RAM access, quick DONE
        cpu_write(17, 4'b1111, 32'hCAFEF00D);
        w0 = wr_cnt;
        d0 = done_cnt;
        start_cmd(2'b11, 8'h77);
        wait_done(1'b0, 1'b0, cyc);
        check("rsv_done_soon", 32'(cyc <= 2), 32'd1);
        finish_op(d0);
        check("rsv_no_writes", 32'(wr_cnt - w0), 32'd0);
        compare_mem("rsv_words");

        // Reset in the middle of a clear
        preload(2);
        start_cmd(2'b00, 8'h55);
        repeat (299) step();
        #2;
        RESET_N = 1'b0;
        #1;
        check("mid_rst_busy", BUSY, 1'b0);
        check("mid_rst_ready", CMD_READY, 1'b1);
        check("mid_rst_we", RAM_WE, 1'b0);
        check("mid_rst_done", DONE, 1'b0);
        check("mid_rst_addr", 32'(RAM_ADDR), 32'd0);
        w0 = wr_cnt;
        repeat (5) step();
        RESET_N = 1'b1;
        repeat (50) step();
        check("mid_rst_no_writes", 32'(wr_cnt - w0), 32'd0);
        for (int i = 0; i < 299; i++) model[i] = 32'h0;
        compare_mem("mid_rst_words");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
